// File: rtl/vga_scan_controller.sv
// 640x480@60 Hz VGA raster generator: pixel divider, x/y scan counters, sprite/background
// colour merge and a one-pixel output stage that keeps colour, syncs and blanking aligned.
module vga_scan_controller #(
    parameter int          CLK_DIV  = 2,
    parameter int          H_ACTIVE = 640,
    parameter int          H_FRONT  = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BACK   = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FRONT  = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BACK   = 33,
    parameter logic [7:0]  BG_COLOR = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  sprite_r,
    input  logic [7:0]  sprite_g,
    input  logic [7:0]  sprite_b,
    input  logic        sprite_visible,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        pixel_tick,
    output logic        frame_tick,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        vga_clk
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic             vga_clk_q, vga_clk_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
    logic             hs_q, hs_d, vs_q, vs_d;
    logic             blank_n_q, blank_n_d;
    logic             frame_tick_q, frame_tick_d;

    logic             active;
    logic             hs_raw;
    logic             vs_raw;
    logic [7:0]       colour_r, colour_g, colour_b;

    always_comb begin
        pixel_tick = (div_q == DIV_LAST);
        div_d      = pixel_tick ? '0 : div_q + 1'b1;
        vga_clk_d  = (div_d >= DIV_HALF);

        x_d = x_q;
        y_d = y_q;
        if (pixel_tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // Raster decode uses the coordinate currently published to the sprite layer.
    always_comb begin
        active = (x_q < H_ACT) && (y_q < V_ACT);
        hs_raw = !((x_q >= HS_START) && (x_q < HS_END));
        vs_raw = !((y_q >= VS_START) && (y_q < VS_END));

        colour_r = 8'h00;
        colour_g = 8'h00;
        colour_b = 8'h00;
        if (active) begin
            if (sprite_visible) begin
                colour_r = sprite_r;
                colour_g = sprite_g;
                colour_b = sprite_b;
            end else begin
                colour_r = BG_COLOR;
                colour_g = BG_COLOR;
                colour_b = BG_COLOR;
            end
        end
    end

    always_comb begin
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        if (pixel_tick) begin
            r_d       = colour_r;
            g_d       = colour_g;
            b_d       = colour_b;
            hs_d      = hs_raw;
            vs_d      = vs_raw;
            blank_n_d = active;
        end
        frame_tick_d = pixel_tick && (x_q == H_ACT_LAST) && (y_q == V_ACT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            vga_clk_q    <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            blank_n_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            vga_clk_q    <= vga_clk_d;
            x_q          <= x_d;
            y_q          <= y_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            blank_n_q    <= blank_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign frame_tick  = frame_tick_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = vga_clk_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench for vga_scan_controller with a per-pixel scoreboard; the vertical timing is
// shortened so that whole frames fit in a short run while the horizontal timing stays real.
module tb_vga_scan_controller;

    localparam int         CLK_DIV  = 2;
    localparam int         H_ACTIVE = 640;
    localparam int         H_FRONT  = 16;
    localparam int         H_SYNC   = 96;
    localparam int         H_BACK   = 48;
    localparam int         V_ACTIVE = 4;
    localparam int         V_FRONT  = 1;
    localparam int         V_SYNC   = 2;
    localparam int         V_BACK   = 1;
    localparam logic [7:0] BG       = 8'h35;

    localparam int H_TOTAL    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int FRAME_CLKS = H_TOTAL * V_TOTAL * CLK_DIV;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       blank;
    } dac_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] sprite_r, sprite_g, sprite_b;
    logic       sprite_visible;
    logic [9:0] x_pos, y_pos;
    logic       pixel_tick, frame_tick;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;

    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    int   m_div, m_x, m_y;
    logic m_frame;
    dac_t m_dac;
    dac_t sb[$];
    bit   rand_sprite = 1'b0;

    vga_scan_controller #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC),
        .H_BACK(H_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC),
        .V_BACK(V_BACK), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sprite_r(sprite_r), .sprite_g(sprite_g), .sprite_b(sprite_b),
        .sprite_visible(sprite_visible),
        .x_pos(x_pos), .y_pos(y_pos), .pixel_tick(pixel_tick), .frame_tick(frame_tick),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n), .vga_clk(vga_clk)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_div   = 0;
        m_x     = 0;
        m_y     = 0;
        m_frame = 1'b0;
        m_dac   = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
        sb.delete();
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_x"}, 32'(x_pos), 32'd0);
        checkOutput({tag, "_y"}, 32'(y_pos), 32'd0);
        checkOutput({tag, "_tick"}, 32'(pixel_tick), 32'd0);
        checkOutput({tag, "_frame"}, 32'(frame_tick), 32'd0);
        checkOutput({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
        checkOutput({tag, "_hs"}, 32'(vga_hs), 32'd1);
        checkOutput({tag, "_vs"}, 32'(vga_vs), 32'd1);
        checkOutput({tag, "_blank_n"}, 32'(vga_blank_n), 32'd0);
        checkOutput({tag, "_sync_n"}, 32'(vga_sync_n), 32'd0);
        checkOutput({tag, "_vga_clk"}, 32'(vga_clk), 32'd0);
    endtask

    // One system clock: queue the expected DAC word if this edge is a pixel tick, then
    // advance the reference raster and compare every observable output.
    task automatic applyStimulus();
        bit   tick_now;
        bit   act;
        dac_t rec;
        tick_now = (m_div == CLK_DIV - 1);
        if (tick_now) begin
            act       = (m_x < H_ACTIVE) && (m_y < V_ACTIVE);
            rec.hs    = !((m_x >= H_ACTIVE + H_FRONT) && (m_x < H_ACTIVE + H_FRONT + H_SYNC));
            rec.vs    = !((m_y >= V_ACTIVE + V_FRONT) && (m_y < V_ACTIVE + V_FRONT + V_SYNC));
            rec.blank = act;
            if (!act)
                {rec.r, rec.g, rec.b} = 24'h0;
            else if (sprite_visible)
                {rec.r, rec.g, rec.b} = {sprite_r, sprite_g, sprite_b};
            else
                {rec.r, rec.g, rec.b} = {BG, BG, BG};
            sb.push_back(rec);
        end
        @(posedge clk);
        #1;
        cycle++;
        m_frame = tick_now && (m_x == H_ACTIVE - 1) && (m_y == V_ACTIVE - 1);
        if (tick_now) begin
            if (m_x == H_TOTAL - 1) begin
                m_x = 0;
                m_y = (m_y == V_TOTAL - 1) ? 0 : m_y + 1;
            end else begin
                m_x++;
            end
            m_div = 0;
            m_dac = sb.pop_front();
        end else begin
            m_div++;
        end
        checkOutput("x_pos", 32'(x_pos), 32'(m_x));
        checkOutput("y_pos", 32'(y_pos), 32'(m_y));
        checkOutput("pixel_tick", 32'(pixel_tick), 32'(m_div == CLK_DIV - 1));
        checkOutput("frame_tick", 32'(frame_tick), 32'(m_frame));
        checkOutput("dac_rgb", 32'({vga_r, vga_g, vga_b}), 32'({m_dac.r, m_dac.g, m_dac.b}));
        checkOutput("dac_sync", 32'({vga_hs, vga_vs, vga_blank_n}), 32'({m_dac.hs, m_dac.vs, m_dac.blank}));
        if (rand_sprite) begin
            sprite_r       = 8'($urandom);
            sprite_g       = 8'($urandom);
            sprite_b       = 8'($urandom);
            sprite_visible = 1'($urandom);
        end
    endtask

    // Advance until (tx,ty) is on the counters and the next edge is a pixel tick.
    task automatic step_to(input int tx, input int ty);
        int n;
        n = 0;
        while (!(m_x == tx && m_y == ty && m_div == CLK_DIV - 1) && n < 2 * FRAME_CLKS) begin
            applyStimulus();
            n++;
        end
        checkOutput("step_to_bound", 32'(n < 2 * FRAME_CLKS), 32'd1);
    endtask

    task automatic set_sprite(input logic [7:0] c, input logic vis);
        sprite_r       = c;
        sprite_g       = c;
        sprite_b       = c;
        sprite_visible = vis;
    endtask

    initial begin
        int n;
        int low_clks;
        int low_ticks;
        int ticks;
        int ft_count;
        int ft_time[2];
        bit saw_ft;

        set_sprite(8'h00, 1'b0);
        #5 rst_n = 1'b0;
        #1 check_reset_values("por");
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus();
        checkOutput("tick_before_edge2", 32'(pixel_tick), 32'd1);
        applyStimulus();
        checkOutput("x_after_first_tick", 32'(x_pos), 32'd1);
        applyStimulus();

        // Asynchronous reset while the divider sits mid-count.
        #3 rst_n = 1'b0;
        #1 check_reset_values("async_mid");
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;

        step_to(100, 1);
        set_sprite(8'hff, 1'b1);
        applyStimulus();
        checkOutput("sprite_colour", 32'({vga_r, vga_g, vga_b}), 32'h00ff_ffff);
        checkOutput("sprite_blank_n", 32'(vga_blank_n), 32'd1);
        set_sprite(8'h12, 1'b0);
        applyStimulus();
        checkOutput("hold_between_ticks", 32'(vga_r), 32'hff);
        set_sprite(8'h5a, 1'b1);
        #2 set_sprite(8'h77, 1'b0);
        applyStimulus();
        checkOutput("bg_colour", 32'({vga_r, vga_g, vga_b}), 32'({BG, BG, BG}));

        step_to(700, 1);
        set_sprite(8'hff, 1'b1);
        applyStimulus();
        checkOutput("porch_colour", 32'({vga_r, vga_g, vga_b}), 32'd0);
        checkOutput("porch_blank_n", 32'(vga_blank_n), 32'd0);

        step_to(H_ACTIVE + H_FRONT, 1);
        applyStimulus();
        checkOutput("hs_fall", 32'(vga_hs), 32'd0);
        low_clks  = 0;
        low_ticks = 0;
        n         = 0;
        while (vga_hs === 1'b0 && n < 4000) begin
            if (pixel_tick === 1'b1) low_ticks++;
            low_clks++;
            applyStimulus();
            n++;
        end
        checkOutput("hs_low_ticks", 32'(low_ticks), 32'(H_SYNC));
        checkOutput("hs_low_clks", 32'(low_clks), 32'(H_SYNC * CLK_DIV));

        step_to(H_TOTAL - 1, 1);
        applyStimulus();
        checkOutput("hwrap_x", 32'(x_pos), 32'd0);
        checkOutput("hwrap_y", 32'(y_pos), 32'd2);

        step_to(0, V_ACTIVE + V_FRONT);
        applyStimulus();
        checkOutput("vs_fall", 32'(vga_vs), 32'd0);
        step_to(0, V_ACTIVE + V_FRONT + V_SYNC);
        applyStimulus();
        checkOutput("vs_rise", 32'(vga_vs), 32'd1);

        step_to(H_TOTAL - 1, V_TOTAL - 1);
        applyStimulus();
        checkOutput("vwrap_x", 32'(x_pos), 32'd0);
        checkOutput("vwrap_y", 32'(y_pos), 32'd0);

        rand_sprite = 1'b1;
        ft_count    = 0;
        n           = 0;
        while (ft_count < 2 && n < 3 * FRAME_CLKS) begin
            applyStimulus();
            n++;
            if (frame_tick === 1'b1) begin
                ft_time[ft_count] = cycle;
                ft_count++;
            end
        end
        rand_sprite = 1'b0;
        checkOutput("frame_tick_count", 32'(ft_count), 32'd2);
        checkOutput("frame_spacing", 32'(ft_time[1] - ft_time[0]), 32'(FRAME_CLKS));

        // Reset in the middle of the active area restarts the raster cleanly.
        step_to(320, 2);
        #3 rst_n = 1'b0;
        #1 check_reset_values("mid_frame");
        reset_model();
        @(negedge clk);
        rst_n  = 1'b1;
        ticks  = 0;
        saw_ft = 1'b0;
        n      = 0;
        while (vga_hs !== 1'b0 && n < 4000) begin
            if (pixel_tick === 1'b1) ticks++;
            applyStimulus();
            n++;
            if (frame_tick === 1'b1) saw_ft = 1'b1;
        end
        // Tick k shows pixel k-1, so the pixel at x=656 reaches the pins on tick 657.
        checkOutput("restart_hs_ticks", 32'(ticks), 32'(H_ACTIVE + H_FRONT + 1));
        checkOutput("restart_no_frame_tick", 32'(saw_ft), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
